riscv_writeback_unit: RTL and testbench
=======================================

// Module: riscv_writeback_unit
// PURPOSE
//  Write side of the integer register file: arbitrates ALU and load/mem results onto the single
//  rd_we/rd_addr/rd_data write port. Keeps a per-register pending scoreboard so issue logic can
//  stall on RAW hazards. Sits between the execute/memory stages and the register file.
// PARAMETERS
//  XLEN          32  data width of result channels and write port
//  STARVE_LIMIT  4   max consecutive mem grants while alu_valid is held before ALU gets one grant (>=1)
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset
//  alu_valid      in   1     ALU result available
//  alu_ready      out  1     ALU result accepted this cycle
//  alu_rd         in   5     ALU destination register
//  alu_data       in   XLEN  ALU result
//  mem_valid      in   1     load result available
//  mem_ready      out  1     load result accepted this cycle
//  mem_rd         in   5     load destination register
//  mem_data       in   XLEN  load result
//  rd_we          out  1     register file write enable (registered)
//  rd_addr        out  5     register file write address (registered)
//  rd_data        out  XLEN  register file write data (registered)
//  iss_valid      in   1     instruction issued with a destination register
//  iss_rd         in   5     its destination register
//  rs1_addr       in   5     issue-stage source 1 lookup
//  rs2_addr       in   5     issue-stage source 2 lookup
//  rs1_busy       out  1     rs1 has an outstanding write (combinational)
//  rs2_busy       out  1     rs2 has an outstanding write (combinational)
//  fwd_rs1_valid  out  1     bypass hit for rs1 (WB_BYPASS_EN only, else 0)
//  fwd_rs2_valid  out  1     bypass hit for rs2 (WB_BYPASS_EN only, else 0)
//  fwd_rs1_data   out  XLEN  bypass data for rs1 (WB_BYPASS_EN only, else 0)
//  fwd_rs2_data   out  XLEN  bypass data for rs2 (WB_BYPASS_EN only, else 0)
// BEHAVIOUR
//  - Reset: rst synchronous, active-high; clk rising edge. In reset: rd_we=0, rd_addr=0, rd_data=0,
//    pending[31:0]=0, starve_cnt=0; alu_ready/mem_ready forced 0.
//  - Handshake: transfer on valid&ready. Sources hold valid/rd/data stable until accepted.
//    valid must not depend on ready; ready may depend on both valids (combinational).
//  - Arbitration, one grant per cycle: mem wins by default. Exception: ALU wins if
//    alu_valid & starve_cnt==STARVE_LIMIT. A lone valid channel is always granted.
//  - starve_cnt: +1 when mem granted while alu_valid=1 (saturate at STARVE_LIMIT); cleared to 0
//    on any ALU grant or any cycle with alu_valid=0.
//  - Latency 1: accept at edge N -> rd_we/rd_addr/rd_data valid during cycle N+1; regfile writes at
//    end of N+1. No accept -> rd_we=0 next cycle (rd_addr/rd_data hold).
//  - rd==0 results: accepted (ready=1) but rd_we stays 0; never write x0.
//  - Scoreboard: pending[iss_rd] set at edge when iss_valid & iss_rd!=0. Cleared at edge where
//    rd_we=1 for rd_addr (write actually lands). Same reg set+clear same edge -> set wins.
//    pending[0] constant 0.
//  - rsN_busy = pending[rsN_addr]; rsN_addr==0 -> busy 0. Same-cycle iss_valid not visible until next cycle.
//  - No ordering check between channels: issue logic must not issue a second writer to a pending rd.
// CONFIGURATION
//  WB_BYPASS_EN defined: if rd_we & rd_addr==rsN_addr & rsN_addr!=0 then fwd_rsN_valid=1,
//    fwd_rsN_data=rd_data, rsN_busy=0 (pending clear still at end of cycle).
//  WB_BYPASS_EN undefined: fwd_* tied 0; rsN_busy reflects pending only (stall one extra cycle).
// TESTING
//  1 Reset: assert rst 2 cycles with both valids high -> readies 0, rd_we 0, rs1_busy 0 for all addrs.
//  2 ALU only: alu_rd=5, data=0x1234_5678 -> alu_ready same cycle, next cycle rd_we=1 rd_addr=5
//    rd_data=0x12345678; following cycle rd_we=0.
//  3 Collision: both valid, mem_rd=3/0xAAAA, alu_rd=4/0xBBBB -> mem first, ALU next cycle;
//    mem_valid held continuously -> ALU granted after exactly STARVE_LIMIT=4 mem grants.
//  4 Scoreboard: iss_valid rd=7 -> rs1_addr=7 busy from next cycle; mem write rd=7 accepted ->
//    busy through rd_we cycle (bypass undefined), 0 after; with WB_BYPASS_EN busy 0 and
//    fwd_rs1_data=write data during rd_we cycle.
//  5 x0: alu_rd=0 data=0xFFFF_FFFF -> alu_ready=1, rd_we stays 0; iss_rd=0 -> no busy.
//  6 Set/clear race: write to rd=9 committing (rd_we=1) while iss_valid rd=9 -> pending[9]=1 after edge.

Source files
------------

// File: rtl/riscv_writeback_unit.sv
// riscv_writeback_unit: arbitrates ALU/load results onto the regfile write port and tracks pending writes for RAW stalls.
// Optional WB_BYPASS_EN forwards the in-flight write to the issue-stage lookups.
module riscv_writeback_unit #(
  parameter int XLEN = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            fwd_rs1_valid,
  output logic            fwd_rs2_valid,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic [XLEN-1:0] fwd_rs2_data
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic rd_we_q, rd_we_d;
  logic [4:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [31:0] pending_q, pending_d;
  logic alu_win, mem_win, acc, hit1, hit2;
  logic [4:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  always_comb begin
    alu_win = alu_valid & (~mem_valid | (starve_cnt_q == LIM));
    mem_win = mem_valid & ~alu_win;
    alu_ready = ~rst & alu_win;
    mem_ready = ~rst & mem_win;
    acc = alu_win | mem_win;
    sel_rd = alu_win ? alu_rd : mem_rd;
    sel_data = alu_win ? alu_data : mem_data;
    // a waiting ALU that loses can only have lost to mem below the limit, so no explicit saturation
    starve_cnt_d = (rst | ~alu_valid | alu_win) ? '0 : starve_cnt_q + CW'(1);
    rd_we_d = ~rst & acc & (sel_rd != 5'd0);
    rd_addr_d = rst ? '0 : acc ? sel_rd : rd_addr_q;
    rd_data_d = rst ? '0 : acc ? sel_data : rd_data_q;
    pending_d = pending_q;
    if (rd_we_q) pending_d[rd_addr_q] = 1'b0;
    if (iss_valid) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
    if (rst) pending_d = '0;
  end
  always_ff @(posedge clk) begin
    starve_cnt_q <= starve_cnt_d;
    rd_we_q <= rd_we_d;
    rd_addr_q <= rd_addr_d;
    rd_data_q <= rd_data_d;
    pending_q <= pending_d;
  end
`ifdef WB_BYPASS_EN
  assign hit1 = rd_we_q & (rd_addr_q == rs1_addr) & (rs1_addr != 5'd0);
  assign hit2 = rd_we_q & (rd_addr_q == rs2_addr) & (rs2_addr != 5'd0);
  assign fwd_rs1_data = hit1 ? rd_data_q : '0;
  assign fwd_rs2_data = hit2 ? rd_data_q : '0;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
`endif
  assign fwd_rs1_valid = hit1;
  assign fwd_rs2_valid = hit2;
  assign rs1_busy = pending_q[rs1_addr] & ~hit1;
  assign rs2_busy = pending_q[rs2_addr] & ~hit2;
  assign rd_we = rd_we_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_riscv_writeback_unit.sv
// tb_riscv_writeback_unit: directed + random stimulus, reference model predicts grants, writes and busy flags.
module tb_riscv_writeback_unit;
  localparam int XLEN = 32;
  localparam int SL = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic alu_valid, alu_ready, mem_valid, mem_ready, rd_we, iss_valid;
  logic [4:0] alu_rd, mem_rd, rd_addr, iss_rd, rs1_addr, rs2_addr;
  logic [XLEN-1:0] alu_data, mem_data, rd_data, fwd_rs1_data, fwd_rs2_data;
  logic rs1_busy, rs2_busy, fwd_rs1_valid, fwd_rs2_valid;

  riscv_writeback_unit #(.XLEN(XLEN), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .fwd_rs1_valid(fwd_rs1_valid), .fwd_rs2_valid(fwd_rs2_valid),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct {int c; logic [4:0] a; logic [XLEN-1:0] d;} wr_t;
  wr_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, waited = 0;
  bit pend[32];
  bit alu_g, mem_g, lw_v;
  logic [4:0] lw_a;
  logic [XLEN-1:0] lw_d;
  logic alu_r, mem_r;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic chk_port(input string n, input logic [4:0] rs, input logic busy, input logic fv,
                          input logic [XLEN-1:0] fd);
    bit hit;
    hit = BYP && lw_v && lw_a == rs && rs != 0;
    chk({n, "_busy"}, busy, rs != 0 && pend[rs] && !hit);
    chk({n, "_fwd_valid"}, fv, hit);
    if (hit || !BYP) chk({n, "_fwd_data"}, fd, hit ? lw_d : '0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // reference model: decides grants, predicts busy/forward, schedules expected writes
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      chk("rst_rd_we", rd_we, 0);
      chk("rst_rs1_busy", rs1_busy, 0);
      waited = 0; lw_v = 0; alu_g = 0; mem_g = 0;
      foreach (pend[i]) pend[i] = 0;
    end else begin
      alu_g = alu_valid && (!mem_valid || waited == SL);
      mem_g = mem_valid && !alu_g;
      chk("alu_ready", alu_ready, alu_g);
      chk("mem_ready", mem_ready, mem_g);
      chk_port("rs1", rs1_addr, rs1_busy, fwd_rs1_valid, fwd_rs1_data);
      chk_port("rs2", rs2_addr, rs2_busy, fwd_rs2_valid, fwd_rs2_data);
      waited = (mem_g && alu_valid) ? waited + 1 : 0;
      if (lw_v) pend[lw_a] = 0;
      if (iss_valid && iss_rd != 0) pend[iss_rd] = 1;
      lw_v = (alu_g && alu_rd != 0) || (mem_g && mem_rd != 0);
      lw_a = alu_g ? alu_rd : mem_rd;
      lw_d = alu_g ? alu_data : mem_data;
      if (lw_v) exp_q.push_back('{cyc + 1, lw_a, lw_d});
    end
  end

  // monitor: every write the DUT presents must match the oldest scheduled one
  initial forever begin
    wr_t e;
    @(posedge clk);
    #2;
    if (rd_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_write actual=addr %0d data %0h required=no write (cycle %0d)", rd_addr, rd_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wb_cycle", cyc, e.c);
        chk("wb_addr", rd_addr, e.a);
        chk("wb_data", rd_data, e.d);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    alu_r = alu_ready;
    mem_r = mem_ready;
    @(posedge clk);
    #1;
    if (alu_g) alu_valid = 0;
    if (mem_g) mem_valid = 0;
    iss_valid = 0;
  endtask

  initial begin
    int n;
    rst = 1; alu_valid = 1; mem_valid = 1; alu_rd = 1; mem_rd = 2; alu_data = 1; mem_data = 2;
    iss_valid = 1; iss_rd = 3; rs1_addr = 3; rs2_addr = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rs1_addr = 5'(i * 11 + 3); rs2_addr = 5'(i * 7 + 1);
    end
    rst = 0; alu_valid = 0; mem_valid = 0; iss_valid = 0; rs1_addr = 3;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
    step(); chk("alu_only_ready", alu_r, 1);
    step(); step();
    alu_valid = 1; alu_rd = 4; alu_data = 32'hBBBB; mem_valid = 1; mem_rd = 3; mem_data = 32'hAAAA; n = 0;
    for (int i = 0; i < 20 && alu_valid; i++) begin
      step();
      n += int'(mem_r);
      if (!mem_valid) begin mem_valid = 1; mem_data = $urandom; end
    end
    chk("starve_mem_grants", n, SL);
    step();
    iss_valid = 1; iss_rd = 7; rs1_addr = 7; rs2_addr = 0;
    step(); step(); step();
    mem_valid = 1; mem_rd = 7; mem_data = 32'hCAFE_0007;
    step(); step(); step();
    alu_valid = 1; alu_rd = 0; alu_data = '1; iss_valid = 1; iss_rd = 0; rs1_addr = 0;
    step(); chk("x0_alu_ready", alu_r, 1);
    step(); step();
    mem_valid = 1; mem_rd = 9; mem_data = 32'h9999; rs1_addr = 9;
    step();
    iss_valid = 1; iss_rd = 9;
    step(); step();
    chk("race_pending_set", rs1_busy, 1);
    for (int i = 0; i < 2000; i++) begin
      if (!alu_valid && $urandom % 3 != 0) begin alu_valid = 1; alu_rd = 5'($urandom); alu_data = $urandom; end
      if (!mem_valid && $urandom % 4 != 0) begin mem_valid = 1; mem_rd = 5'($urandom); mem_data = $urandom; end
      iss_valid = ($urandom % 3 == 0); iss_rd = 5'($urandom);
      rs1_addr = ($urandom % 2 == 1) ? lw_a : 5'($urandom);
      rs2_addr = ($urandom % 2 == 1) ? lw_a : 5'($urandom);
      step();
    end
    for (int i = 0; i < 10 && (alu_valid || mem_valid); i++) step();
    step(); step();
    chk("drain_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
